// File: rtl/arb_port_mux_pkg.sv
// arb_port_mux_pkg: FSM state encoding and port-index width helper shared by arb_port_mux and its consumers
package arb_port_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PORT_W = port_w(16);

endpackage

// File: rtl/arb_port_mux_rr_arbiter.sv
// rr_arbiter: round-robin arbiter; the pointer holds the last granted port and advances only on arb_round
module rr_arbiter
    import arb_port_mux_pkg::*;
#(
    parameter  int REQ_WIDTH = 16,
    localparam int PW        = port_w(REQ_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQ_WIDTH-1:0] req,
    input  logic                 arb_round,
    output logic [REQ_WIDTH-1:0] gnt,
    output logic [PW-1:0]        arb_port
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cand;
    int            start;
    int            idx;

    // Search from the port after the pointer; the descending loop leaves the nearest requester in arb_port
    always_comb begin
        start    = (int'(ptr_q) >= REQ_WIDTH - 1) ? 0 : int'(ptr_q) + 1;
        idx      = 0;
        cand     = '0;
        arb_port = '0;
        for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
            idx  = start + i;
            idx  = (idx >= REQ_WIDTH) ? idx - REQ_WIDTH : idx;
            cand = PW'(idx);
            if (req[cand]) arb_port = cand;
        end
        gnt           = '0;
        gnt[arb_port] = |req;
        ptr_d         = arb_round ? arb_port : ptr_q;
    end

    // Pointer resets to all-ones so the lowest requesting port wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '1;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/arb_port_mux.sv
// arb_port_mux: packet-locked N:1 stream mux with registered output; ARB_PORT_MUX_BURST_LIMIT_EN caps beats per lock at MAX_BURST
module arb_port_mux
    import arb_port_mux_pkg::*;
#(
    parameter  int NUM_PORT   = 16,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 16,
    localparam int PW         = port_w(NUM_PORT)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORT-1:0]            in_vld,
    input  logic [NUM_PORT*DATA_WIDTH-1:0] in_dat,
    input  logic [NUM_PORT-1:0]            in_last,
    output logic [NUM_PORT-1:0]            in_rdy,
    output logic                           out_vld,
    output logic [DATA_WIDTH-1:0]          out_dat,
    output logic                           out_last,
    output logic [PW-1:0]                  out_port,
    input  logic                           out_rdy
);

    state_e                state_q, state_d;
    logic [PW-1:0]         cur_port_q, cur_port_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
    logic                  out_last_q, out_last_d;
    logic [PW-1:0]         out_port_q, out_port_d;
    logic [DATA_WIDTH-1:0] dat_arr [NUM_PORT];
    logic [PW-1:0]         arb_port;
    logic                  arb_round;
    logic                  rdy_lock;
    logic                  acc;
    logic                  burst_end;

    for (genvar g = 0; g < NUM_PORT; g++) begin : g_unpack
        assign dat_arr[g] = in_dat[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(.REQ_WIDTH(NUM_PORT)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_vld),
        .arb_round (arb_round),
        .gnt       (),
        .arb_port  (arb_port)
    );

    // Lock/arbitrate FSM, per-port ready and output register next-state
    always_comb begin
        state_d    = state_q;
        cur_port_d = cur_port_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_last_d = out_last_q;
        out_port_d = out_port_q;
        in_rdy     = '0;
        arb_round  = 1'b0;
        acc        = 1'b0;
        rdy_lock   = ~out_vld_q | out_rdy;
        if (state_q == IDLE) begin
            arb_round = |in_vld;
            if (|in_vld) begin
                state_d    = LOCK;
                cur_port_d = arb_port;
            end
        end else begin
            in_rdy[cur_port_q] = rdy_lock;
            acc                = in_vld[cur_port_q] & rdy_lock;
            if (acc & (in_last[cur_port_q] | burst_end)) state_d = IDLE;
        end
        if (acc) begin
            out_vld_d  = 1'b1;
            out_dat_d  = dat_arr[cur_port_q];
            out_last_d = in_last[cur_port_q];
            out_port_d = cur_port_q;
        end else if (out_rdy) begin
            out_vld_d  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_port_q <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            out_port_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_port_q <= cur_port_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
            out_port_q <= out_port_d;
        end
    end

`ifdef ARB_PORT_MUX_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Beats accepted in the current lock; the MAX_BURST-th accept releases the lock
    always_comb begin
        cnt_d     = (state_q == IDLE) ? '0 : cnt_q + CW'(acc);
        burst_end = (cnt_q == CW'(MAX_BURST - 1));
    end

    // Beat counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign burst_end = 1'b0;
`endif

    assign out_vld  = out_vld_q;
    assign out_dat  = out_dat_q;
    assign out_last = out_last_q;
    assign out_port = out_port_q;

endmodule
